noc_trace_tap: RTL and testbench
================================

NOC_TRACE_TAP -- requirements
Module: noc_trace_tap

Interface
REQ-001 Parameter NE, default 4, number of monitored endpoints; legal range 2..8.
REQ-002 Parameter Fw, default 36, flit width; the header flag is bit Fw-1 and the tail flag is bit Fw-2.
REQ-003 Parameter Fpay, default 32, payload width and trace word width.
REQ-004 Parameter QD, default 4, depth of each per-endpoint queue; power of two, 2..16.
REQ-005 Port clk, input, 1 bit, the single clock.
REQ-006 Port reset, input, 1 bit, synchronous active-high reset.
REQ-007 Port flit_in_all, input, NE*Fw bits, flits concatenated; endpoint i occupies [(i+1)*Fw-1 : i*Fw].
REQ-008 Port flit_in_wr_all, input, NE bits, per-endpoint flit-valid strobe.
REQ-009 Port trace_en, input, 1 bit, capture enable.
REQ-010 Port tb_full, input, 1 bit, backpressure from the downstream trace_buffer.
REQ-011 Port tb_din, output, Fpay bits, trace word to trace_buffer din.
REQ-012 Port tb_wr, output, 1 bit, trace word write strobe to trace_buffer wr_en.
REQ-013 Port drop_cnt, output, 16 bits, count of dropped flits.
REQ-014 Port overflow, output, 1 bit, sticky drop indicator.

Function
REQ-015 Each endpoint i SHALL have a QD-entry FIFO; a capture push occurs when flit_in_wr_all[i]=1, trace_en=1, and the flit is eligible (REQ-027).
REQ-016 Each queued entry SHALL be {i as 3 bits, header flag, tail flag, flit[Fpay-6:0]}, Fpay bits total.
REQ-017 Pop eligibility SHALL be: at least one queue non-empty and tb_full=0; otherwise tb_wr=0.
REQ-018 A round-robin arbiter SHALL grant one non-empty queue per eligible cycle.
  - The pointer starts at 0 after reset.
  - After a grant to queue i, the pointer SHALL become (i+1) mod NE.
  - The pointer SHALL hold when nothing is granted.
REQ-019 tb_din and tb_wr SHALL be registered; a flit pushed at edge N SHALL appear with tb_wr=1 at edge N+1 at the earliest (latency 1).
REQ-020 tb_wr SHALL be high for exactly one cycle per popped entry; tb_din is don't-care when tb_wr=0.
REQ-021 A push into a full queue that is not popped in the same cycle SHALL be dropped:
  - drop_cnt increments, saturating at 16'hFFFF.
  - overflow is set to 1 and holds until reset.
REQ-022 Push and pop on the same queue in the same cycle SHALL both succeed regardless of occupancy; this includes the full case, which is not a drop.
REQ-023 Simultaneous drops on k endpoints in one cycle SHALL add k to drop_cnt, with saturation.
REQ-024 trace_en=0 SHALL block new pushes only; queued entries continue to drain, and flits arriving while disabled are not counted as drops.
REQ-025 Order SHALL be preserved per endpoint; no ordering is guaranteed across endpoints beyond the arbitration of REQ-018.

Reset
REQ-026 When reset=1 at a clock edge, the block SHALL:
  - empty all queues;
  - set the arbiter pointer to 0;
  - drive tb_wr=0, tb_din=0, drop_cnt=0 and overflow=0.
  This applies mid-stream; in-flight entries are discarded.

Configuration
REQ-027 Macro NOC_TRACE_HDR_ONLY_EN:
  - Defined: only flits with the header flag set are eligible; body and tail flits are ignored and never counted as drops.
  - Undefined: all flits are eligible.

Verification
REQ-028 The bench SHALL cover the following scenarios:
  - Single flit: reset, then a header flit payload 0x0000_1234 on endpoint 2 with trace_en=1. Required: tb_wr=1 one cycle later, tb_din[31:29]=3'd2, tb_din[28:27]=2'b10.
  - All endpoints in one cycle: all 4 strobes high, tb_full=0. Required: 4 consecutive tb_wr pulses in endpoint order 0,1,2,3; then a second burst starting with 0 again.
  - Backpressure and drops: tb_full=1 while 6 flits are pushed on endpoint 1 (QD=4). Required: drop_cnt=2, overflow=1; after tb_full drops to 0, exactly 4 words drain in push order.
  - Full queue with tb_full=0: endpoint 0 holds 4 entries and a push coincides with a pop. Required: no drop, drop_cnt unchanged.
  - Reset mid-drain: assert reset with 3 entries queued. Required: tb_wr=0 from the next cycle, no stale words after release, drop_cnt=0.
  - Macro defined: send a header, body, tail packet. Required: exactly 1 tb_wr pulse, drop_cnt=0.

Source files
------------

// File: rtl/noc_trace_tap.sv
`default_nettype none
// ============================================================================
// Module   : noc_trace_tap
// Purpose  : Taps up to NE NoC endpoint flit streams into per-endpoint queues
//            and merges them round-robin into one trace word stream for a
//            downstream trace_buffer. Drops are counted and flagged.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            flit_in_all         - NE flits, endpoint i at [(i+1)*Fw-1 : i*Fw]
//            flit_in_wr_all      - per-endpoint flit-valid strobes
//            trace_en            - capture enable (queues still drain when 0)
//            tb_full             - backpressure from trace_buffer
//            tb_din / tb_wr      - registered trace word and write strobe
//            drop_cnt            - saturating count of dropped flits
//            overflow            - sticky drop indicator
// Config   : NOC_TRACE_HDR_ONLY_EN - when defined, only header flits are
//            captured; body/tail flits are ignored (never counted as drops).
// Revision : 1.0 - initial release
// ============================================================================
module noc_trace_tap #(
  parameter int NE   = 4,
  parameter int Fw   = 36,
  parameter int Fpay = 32,
  parameter int QD   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NE*Fw-1:0]   flit_in_all,
  input  logic [NE-1:0]      flit_in_wr_all,
  input  logic               trace_en,
  input  logic               tb_full,
  output logic [Fpay-1:0]    tb_din,
  output logic               tb_wr,
  output logic [15:0]        drop_cnt,
  output logic               overflow
);

  localparam int AW = $clog2(QD);
  localparam int CW = AW + 1;
  localparam int PW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [CW-1:0] C_QD = CW'(QD);

  // Queue storage and bookkeeping
  logic [Fpay-1:0] mem_q    [NE][QD];
  logic [Fpay-1:0] mem_d    [NE][QD];
  logic [AW-1:0]   wr_ptr_q [NE];
  logic [AW-1:0]   wr_ptr_d [NE];
  logic [AW-1:0]   rd_ptr_q [NE];
  logic [AW-1:0]   rd_ptr_d [NE];
  logic [CW-1:0]   cnt_q    [NE];
  logic [CW-1:0]   cnt_d    [NE];

  logic [PW-1:0]   rr_q, rr_d;
  logic [Fpay-1:0] tb_din_q, tb_din_d;
  logic            tb_wr_q, tb_wr_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            overflow_q, overflow_d;

  logic [Fpay-1:0] entry [NE];
  logic [NE-1:0]   eligible;
  logic [NE-1:0]   push_req;
  logic [NE-1:0]   push_ok;
  logic [NE-1:0]   drop;
  logic [NE-1:0]   nonempty;
  logic [NE-1:0]   grant;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   cand;
  logic            found;
  logic [3:0]      ndrop;
  logic [16:0]     drop_sum;

  // Only part of each flit is carried into the trace word.
  logic unused_flit_bits;
  assign unused_flit_bits = ^flit_in_all;

  // --------------------------------------------------------------------------
  // Per-endpoint capture qualification and entry formatting
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NE; gi++) begin : g_ep
    logic [Fw-1:0] flit;
    assign flit = flit_in_all[gi*Fw +: Fw];
`ifdef NOC_TRACE_HDR_ONLY_EN
    assign eligible[gi] = flit[Fw-1];
`else
    assign eligible[gi] = 1'b1;
`endif
    assign entry[gi]    = {3'(gi), flit[Fw-1], flit[Fw-2], flit[Fpay-6:0]};
    assign push_req[gi] = flit_in_wr_all[gi] & trace_en & eligible[gi];
    assign nonempty[gi] = (cnt_q[gi] != '0);
  end

  // --------------------------------------------------------------------------
  // Round-robin arbiter: first non-empty queue at or after the pointer.
  // --------------------------------------------------------------------------
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    rr_d    = rr_q;
    if (!tb_full) begin
      for (int k = 0; k < NE; k++) begin
        cand = PW'((int'(rr_q) + k) % NE);
        if (!found && nonempty[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          gnt_idx     = cand;
        end
      end
    end
    if (found) begin
      rr_d = (gnt_idx == PW'(NE - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Queue update. A full queue still accepts a push when it is popped in the
  // same cycle, so only push-into-full-without-pop is a drop.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_d = mem_q;
    ndrop = '0;
    for (int i = 0; i < NE; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      push_ok[i]  = push_req[i] & ((cnt_q[i] != C_QD) | grant[i]);
      drop[i]     = push_req[i] & (cnt_q[i] == C_QD) & ~grant[i];
      ndrop       = ndrop + 4'(drop[i]);
      if (push_ok[i]) begin
        mem_d[i][wr_ptr_q[i]] = entry[i];
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end
      if (grant[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end
      case ({push_ok[i], grant[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output word, drop counter (saturating, k drops add k) and sticky flag
  // --------------------------------------------------------------------------
  always_comb begin
    tb_wr_d    = found;
    tb_din_d   = found ? mem_q[gnt_idx][rd_ptr_q[gnt_idx]] : '0;
    drop_sum   = {1'b0, drop_cnt_q} + 17'(ndrop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d = overflow_q | (|drop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NE; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_q       <= '0;
      tb_din_q   <= '0;
      tb_wr_q    <= 1'b0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_q       <= rr_d;
      tb_din_q   <= tb_din_d;
      tb_wr_q    <= tb_wr_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tb_din   = tb_din_q;
  assign tb_wr    = tb_wr_q;
  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_trace_tap.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_trace_tap
// Purpose  : Self-checking bench for noc_trace_tap. Trace words are checked
//            against per-endpoint expected queues; drop behaviour is checked
//            from a vector table plus directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_trace_tap;

  localparam int NE = 4;
  localparam int FW = 36;
  localparam int FP = 32;
  localparam int QD = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NE*FW-1:0] flit_in_all;
  logic [NE-1:0]    flit_in_wr_all;
  logic             trace_en;
  logic             tb_full;
  logic [FP-1:0]    tb_din;
  logic             tb_wr;
  logic [15:0]      drop_cnt;
  logic             overflow;

  noc_trace_tap #(.NE(NE), .Fw(FW), .Fpay(FP), .QD(QD)) dut (
    .clk            (clk),
    .reset          (reset),
    .flit_in_all    (flit_in_all),
    .flit_in_wr_all (flit_in_wr_all),
    .trace_en       (trace_en),
    .tb_full        (tb_full),
    .tb_din         (tb_din),
    .tb_wr          (tb_wr),
    .drop_cnt       (drop_cnt),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          words_out = 0;
  int          exp_drops = 0;
  logic [FP-1:0] sb [NE][$];
  logic [2:0]  ep_log [$];

  typedef struct {
    logic [NE-1:0] wr;
    logic          en;
    logic          exp_ovf;
    logic [15:0]   exp_drop;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  function automatic bit elig(input bit hdr);
`ifdef NOC_TRACE_HDR_ONLY_EN
    return hdr;
`else
    return 1'b1 | hdr;
`endif
  endfunction

  // One clock; outputs sampled 1ns after the edge and matched to the scoreboard.
  task automatic tick();
    int idx;
    @(posedge clk);
    #1;
    if (tb_wr === 1'b1) begin
      idx = int'(tb_din[31:29]);
      words_out++;
      ep_log.push_back(tb_din[31:29]);
      if (idx >= NE || sb[idx].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%h expected no word", tb_din);
      end else begin
        check("trace_word", tb_din, sb[idx].pop_front());
      end
    end
  endtask

  // Drive one cycle of strobes; pay==0 selects random payloads.
  task automatic drive(input logic [NE-1:0] wr, input bit hdr, input bit tail,
                       input logic [31:0] pay);
    logic [31:0] p;
    for (int i = 0; i < NE; i++) begin
      p = (pay == 32'h0) ? $urandom : pay;
      flit_in_all[i*FW +: FW] = {hdr, tail, 2'b00, p};
      if (wr[i] && trace_en && elig(hdr)) begin
        if (tb_full && sb[i].size() >= QD) exp_drops++;
        else sb[i].push_back({3'(i), hdr, tail, p[26:0]});
      end
    end
    flit_in_wr_all = wr;
    tick();
    flit_in_wr_all = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NE; i++) sb[i].delete();
    tick();
    reset = 1'b0;
    exp_drops = 0;
  endtask

  int n_ep1;
  int total;

  initial begin
    tbl[0] = '{4'b0010, 1'b1, 1'b0, 16'd0};
    tbl[1] = '{4'b0010, 1'b1, 1'b0, 16'd0};
    tbl[2] = '{4'b0010, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{4'b0010, 1'b1, 1'b0, 16'd0};
    tbl[4] = '{4'b0010, 1'b1, 1'b1, 16'd1};
    tbl[5] = '{4'b0010, 1'b1, 1'b1, 16'd2};
    tbl[6] = '{4'b0010, 1'b0, 1'b1, 16'd2};  // disabled: not a drop
    tbl[7] = '{4'b1000, 1'b1, 1'b1, 16'd2};  // other queue still accepts

    reset = 1'b1;
    flit_in_all = '0;
    flit_in_wr_all = '0;
    trace_en = 1'b1;
    tb_full = 1'b0;
    tick();
    tick();
    check("rst_tb_wr", 32'(tb_wr), 32'd0);
    check("rst_tb_din", tb_din, 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Single header flit on endpoint 2
    drive(4'b0100, 1'b1, 1'b0, 32'h0000_1234);
    check("single_not_early", 32'(tb_wr), 32'd0);
    tick();
    check("single_wr", 32'(tb_wr), 32'd1);
    check("single_ep", 32'(tb_din[31:29]), 32'd2);
    check("single_flags", 32'(tb_din[28:27]), 32'b10);
    check("single_word", tb_din, {3'd2, 2'b10, 27'h1234});
    tick();
    check("single_one_pulse", 32'(tb_wr), 32'd0);

    // All endpoints at once, two bursts, each must drain in order 0..3
    do_reset();
    for (int b = 0; b < 2; b++) begin
      ep_log.delete();
      words_out = 0;
      drive(4'hF, 1'b1, 1'b0, 32'h0);
      repeat (4) tick();
      check("burst_words", 32'(words_out), 32'd4);
      for (int k = 0; k < 4; k++)
        check("rr_order", (k < ep_log.size()) ? 32'(ep_log[k]) : 32'hFFFF_FFFF, 32'(k));
    end

    // Backpressure table on endpoint 1
    tb_full = 1'b1;
    for (int r = 0; r < 8; r++) begin
      trace_en = tbl[r].en;
      drive(tbl[r].wr, 1'b1, 1'b0, 32'h0);
      check("tbl_drop_cnt", 32'(drop_cnt), 32'(tbl[r].exp_drop));
      check("tbl_overflow", 32'(overflow), 32'(tbl[r].exp_ovf));
      check("tbl_no_wr", 32'(tb_wr), 32'd0);
    end
    trace_en = 1'b1;
    check("bp_model_drops", 32'(drop_cnt), 32'(exp_drops));
    tb_full = 1'b0;
    ep_log.delete();
    words_out = 0;
    repeat (8) tick();
    n_ep1 = 0;
    foreach (ep_log[k]) if (ep_log[k] == 3'd1) n_ep1++;
    check("bp_ep1_words", 32'(n_ep1), 32'd4);
    check("bp_total_words", 32'(words_out), 32'd5);

    // Full queue on endpoint 0, push coincides with pop: not a drop
    tb_full = 1'b1;
    repeat (4) drive(4'b0001, 1'b1, 1'b0, 32'h0);
    check("fullpop_pre_drop", 32'(drop_cnt), 32'd2);
    tb_full = 1'b0;
    words_out = 0;
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    check("fullpop_drop", 32'(drop_cnt), 32'd2);
    repeat (6) tick();
    check("fullpop_words", 32'(words_out), 32'd5);
    check("fullpop_overflow", 32'(overflow), 32'd1);

    // Simultaneous drops on all endpoints add 4
    tb_full = 1'b1;
    repeat (4) drive(4'hF, 1'b1, 1'b0, 32'h0);
    drive(4'hF, 1'b1, 1'b0, 32'h0);
    check("multi_drop", 32'(drop_cnt), 32'd6);
    tb_full = 1'b0;
    repeat (20) tick();

    // Reset mid-drain
    tb_full = 1'b1;
    repeat (3) drive(4'b1000, 1'b1, 1'b0, 32'h0);
    tb_full = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < NE; i++) sb[i].delete();
    tick();
    check("mid_rst_wr", 32'(tb_wr), 32'd0);
    check("mid_rst_din", tb_din, 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    exp_drops = 0;
    words_out = 0;
    repeat (5) tick();
    check("mid_rst_stale", 32'(words_out), 32'd0);

    // Header / body / tail packet
    words_out = 0;
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    drive(4'b0001, 1'b0, 1'b0, 32'h0);
    drive(4'b0001, 1'b0, 1'b1, 32'h0);
    repeat (4) tick();
`ifdef NOC_TRACE_HDR_ONLY_EN
    check("pkt_words", 32'(words_out), 32'd1);
`else
    check("pkt_words", 32'(words_out), 32'd3);
`endif
    check("pkt_drop", 32'(drop_cnt), 32'd0);

    total = 0;
    for (int i = 0; i < NE; i++) total += sb[i].size();
    check("sb_empty", 32'(total), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
